// File: rtl/osd_link_tx.sv
`timescale 1ns/1ps
// Strobed word transmitter for the OSD link: sends a command word followed by
// cmd_len payload words fetched from a synchronous-read RAM, framed by io_osd.
module osd_link_tx #(
  parameter int STB_HI   = 2,
  parameter int STB_LO   = 3,
  parameter int IDLE_GAP = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [12:0] cmd_len,
  output logic [12:0] pay_addr,
  input  logic [15:0] pay_data,
  output logic        io_osd,
  output logic        io_strobe,
  output logic [15:0] io_din,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, GAP} state_t;

  localparam logic [3:0] HI_LAST  = 4'(STB_HI - 1);
  localparam logic [3:0] LO_LAST  = 4'(STB_LO - 1);
  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [12:0] r_len;
  logic [12:0] r_idx;
  logic        r_fetch;
  logic        r_osd;
  logic        r_strobe;
  logic [15:0] r_din;
  logic [12:0] r_addr;
  logic        r_ready;
  logic        r_busy;
  logic [12:0] w_lenSat;

  assign w_lenSat = (cmd_len > 13'd4096) ? 13'd4096 : cmd_len;

  // r_idx is the next payload index to fetch; r_fetch marks a LO phase that
  // carries a RAM read (address on LO cycle 1, data captured at end of LO cycle 2).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_fetch  <= 1'b0;
      r_osd    <= 1'b0;
      r_strobe <= 1'b0;
      r_din    <= '0;
      r_addr   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_state <= SETUP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_osd   <= 1'b1;
            r_din   <= {8'h00, cmd_code};
            r_len   <= w_lenSat;
            r_idx   <= '0;
            r_cnt   <= '0;
          end
        end
        SETUP: begin
          r_state  <= HI;
          r_strobe <= 1'b1;
          r_cnt    <= '0;
        end
        HI: begin
          if (r_cnt == HI_LAST) begin
            r_state  <= LO;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
            r_fetch  <= (r_idx < r_len);
            if (r_idx < r_len) r_addr <= r_idx;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        LO: begin
          if (r_cnt == 4'd1 && r_fetch) begin
            r_din <= pay_data;
            r_idx <= r_idx + 13'd1;
          end
          if (r_cnt == LO_LAST) begin
            r_cnt <= '0;
            if (r_fetch) begin
              r_state  <= HI;
              r_strobe <= 1'b1;
            end else begin
              r_state <= GAP;
              r_osd   <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign io_osd    = r_osd;
  assign io_strobe = r_strobe;
  assign io_din    = r_din;
  assign pay_addr  = r_addr;

endmodule

// File: tb/tb_osd_link_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for osd_link_tx: expected words and frame lengths are queued
// when commands are issued and checked by a monitor on strobe rises and frame ends.
module tb_osd_link_tx;

  localparam int TB_HI  = 2;
  localparam int TB_LO  = 3;
  localparam int TB_GAP = 2;

  logic        clk_sys;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_code;
  logic [12:0] cmd_len;
  logic [12:0] pay_addr;
  logic [15:0] pay_data;
  logic        io_osd;
  logic        io_strobe;
  logic [15:0] io_din;
  logic        busy;

  logic [15:0] ram [0:4095];
  logic [15:0] expWords[$];
  int          expLens[$];
  int          compared;
  int          mismatched;
  bit          monEn;

  osd_link_tx #(.STB_HI(TB_HI), .STB_LO(TB_LO), .IDLE_GAP(TB_GAP)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_code (cmd_code),
    .cmd_len  (cmd_len),
    .pay_addr (pay_addr),
    .pay_data (pay_data),
    .io_osd   (io_osd),
    .io_strobe(io_strobe),
    .io_din   (io_din),
    .busy     (busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Synchronous-read payload RAM
  always @(posedge clk_sys) pay_data <= ram[pay_addr[11:0]];

  // Monitor: every strobe rise pops one expected word; every frame end pops one length
  bit          prevStrobe;
  bit          prevOsd;
  int          osdRun;
  int          lowRun;
  int          riseInFrame;
  logic [15:0] expW;
  int          expL;
  always @(negedge clk_sys) begin
    if (!monEn) begin
      prevStrobe  = 1'b0;
      prevOsd     = 1'b0;
      osdRun      = 0;
      lowRun      = 0;
      riseInFrame = 0;
    end else begin
      if (io_osd === 1'b1) osdRun++;
      if (io_strobe === 1'b1 && !prevStrobe) begin
        if (riseInFrame > 0) begin
          compared++;
          if (lowRun < TB_LO) begin
            mismatched++;
            $display("[TB] FAIL strobe_low_time: got %0d low cycles, need at least %0d", lowRun, TB_LO);
          end
          compared++;
          if (pay_addr !== 13'(riseInFrame - 1)) begin
            mismatched++;
            $display("[TB] FAIL pay_addr_at_rise: got %0d expected %0d", pay_addr, riseInFrame - 1);
          end
        end
        compared++;
        if (expWords.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_strobe: got io_din=%h with no word expected", io_din);
        end else begin
          expW = expWords.pop_front();
          if (io_din !== expW) begin
            mismatched++;
            $display("[TB] FAIL word_at_rise %0d: got %h expected %h", riseInFrame, io_din, expW);
          end
        end
        riseInFrame++;
      end
      if (io_strobe === 1'b1) lowRun = 0;
      else lowRun++;
      if (io_osd !== 1'b1 && prevOsd) begin
        compared++;
        if (expLens.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL unexpected_frame: got %0d osd cycles with no frame expected", osdRun);
        end else begin
          expL = expLens.pop_front();
          if (osdRun != expL) begin
            mismatched++;
            $display("[TB] FAIL frame_length: got %0d expected %0d", osdRun, expL);
          end
        end
        osdRun      = 0;
        riseInFrame = 0;
      end
      prevStrobe = (io_strobe === 1'b1);
      prevOsd    = (io_osd === 1'b1);
    end
  end

  task automatic push_expected(input logic [7:0] code, input logic [12:0] len);
    int n;
    n = (len > 13'd4096) ? 4096 : int'(len);
    expWords.push_back({8'h00, code});
    for (int i = 0; i < n; i++) expWords.push_back(ram[i]);
    expLens.push_back(1 + (n + 1) * (TB_HI + TB_LO));
  endtask

  task automatic send_cmd(input logic [7:0] code, input logic [12:0] len);
    push_expected(code, len);
    cmd_code  = code;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk_sys);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk_sys);
      compared++;
      if (io_osd !== 1'b0 || cmd_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL reset_hold: got osd=%b ready=%b expected osd=0 ready=1", io_osd, cmd_ready);
      end
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk_sys);
    compared++;
    if ({io_osd, io_strobe, io_din, pay_addr, cmd_ready, busy} !== {1'b0, 1'b0, 16'h0, 13'h0, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL reset_release: got osd=%b stb=%b din=%h addr=%h ready=%b busy=%b expected 0 0 0000 0000 1 0",
               io_osd, io_strobe, io_din, pay_addr, cmd_ready, busy);
    end
    repeat (4) begin
      @(negedge clk_sys);
      compared++;
      if (io_strobe !== 1'b0 || io_osd !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_quiet: got stb=%b osd=%b expected 0 0", io_strobe, io_osd);
      end
    end
  endtask

  task automatic test_cmd0;
    bit expOsd, expStb, expRdy;
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL cmd0_ready_T: got %b expected 1", cmd_ready);
    end
    push_expected(8'h40, 13'd0);
    cmd_code  = 8'h40;
    cmd_len   = 13'd0;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_sys);
      if (k == 1) cmd_valid = 1'b0;
      expOsd = (k <= 6);
      expStb = (k == 2 || k == 3);
      expRdy = (k == 9);
      compared++;
      if (io_osd !== expOsd || io_strobe !== expStb || cmd_ready !== expRdy || busy !== !expRdy) begin
        mismatched++;
        $display("[TB] FAIL cmd0_timing T+%0d: got osd=%b stb=%b ready=%b busy=%b expected %b %b %b %b",
                 k, io_osd, io_strobe, cmd_ready, busy, expOsd, expStb, expRdy, !expRdy);
      end
      compared++;
      if (io_din !== 16'h0040) begin
        mismatched++;
        $display("[TB] FAIL cmd0_din T+%0d: got %h expected 0040", k, io_din);
      end
    end
  endtask

  task automatic test_payload;
    bit ok;
    ram[0] = 16'h0010; ram[1] = 16'h0020; ram[2] = 16'h0005; ram[3] = 16'h0003; ram[4] = 16'h0001;
    send_cmd(8'h41, 13'd5);
    wait_ready(200, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL payload_done: got timeout expected cmd_ready");
    end
    compared++;
    if (pay_addr !== 13'd4 || io_din !== 16'h0001) begin
      mismatched++;
      $display("[TB] FAIL payload_end: got addr=%0d din=%h expected 4 0001", pay_addr, io_din);
    end
    send_cmd(8'h43, 13'd0);
    wait_ready(50, ok);
    compared++;
    if (!ok || pay_addr !== 13'd4) begin
      mismatched++;
      $display("[TB] FAIL len0_addr_kept: got ok=%b addr=%0d expected 1 4", ok, pay_addr);
    end
  endtask

  task automatic test_reset_abort;
    bit ok;
    bit prev;
    int rises;
    prev  = 1'b0;
    rises = 0;
    send_cmd(8'h41, 13'd5);
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(negedge clk_sys);
      if (io_strobe === 1'b1 && !prev) rises++;
      prev = (io_strobe === 1'b1);
    end
    compared++;
    if (rises != 3) begin
      mismatched++;
      $display("[TB] FAIL abort_reach_word2: got %0d rises expected 3", rises);
    end
    monEn = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    compared++;
    if (io_osd !== 1'b0 || io_strobe !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL abort_state: got osd=%b stb=%b ready=%b busy=%b expected 0 0 1 0",
               io_osd, io_strobe, cmd_ready, busy);
    end
    expWords.delete();
    expLens.delete();
    monEn = 1'b1;
    send_cmd(8'h41, 13'd5);
    wait_ready(200, ok);
    compared++;
    if (!ok || expWords.size() != 0 || expLens.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL abort_rerun: got ok=%b words_left=%0d frames_left=%0d expected 1 0 0",
               ok, expWords.size(), expLens.size());
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    bit prevO;
    bit fell;
    bit rose;
    int lowCnt;
    int rdyCnt;
    prevO  = 1'b1;
    fell   = 1'b0;
    rose   = 1'b0;
    lowCnt = 0;
    rdyCnt = 0;
    push_expected(8'h22, 13'd1);
    push_expected(8'h42, 13'd0);
    cmd_code  = 8'h22;
    cmd_len   = 13'd1;
    cmd_valid = 1'b1;
    @(negedge clk_sys);
    cmd_code = 8'h42;
    cmd_len  = 13'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (prevO && io_osd !== 1'b1) fell = 1'b1;
      if (fell && io_osd === 1'b1) begin
        rose = 1'b1;
        break;
      end
      if (fell) lowCnt++;
      if (fell && cmd_ready === 1'b1) rdyCnt++;
      prevO = (io_osd === 1'b1);
    end
    cmd_valid = 1'b0;
    compared++;
    if (!rose || lowCnt != TB_GAP + 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_gap: got rose=%b low=%0d expected 1 %0d", rose, lowCnt, TB_GAP + 1);
    end
    compared++;
    if (rdyCnt != 1) begin
      mismatched++;
      $display("[TB] FAIL b2b_ready_cycles: got %0d expected 1", rdyCnt);
    end
    wait_ready(100, ok);
    compared++;
    if (!ok || expWords.size() != 0 || expLens.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_drain: got ok=%b words_left=%0d frames_left=%0d expected 1 0 0",
               ok, expWords.size(), expLens.size());
    end
  endtask

  task automatic test_max_len(input logic [12:0] len, input logic [7:0] code);
    bit ok;
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i);
    send_cmd(code, len);
    wait_ready(4097 * (TB_HI + TB_LO) + 50, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL maxlen_done len=%0d: got timeout expected cmd_ready", len);
    end
    compared++;
    if (pay_addr !== 13'd4095 || io_din !== 16'h0FFF) begin
      mismatched++;
      $display("[TB] FAIL maxlen_end len=%0d: got addr=%0d din=%h expected 4095 0fff", len, pay_addr, io_din);
    end
    compared++;
    if (expWords.size() != 0 || expLens.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL maxlen_drain len=%0d: got words_left=%0d frames_left=%0d expected 0 0",
               len, expWords.size(), expLens.size());
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    monEn      = 1'b0;
    reset      = 1'b1;
    cmd_valid  = 1'b1;
    cmd_code   = 8'h55;
    cmd_len    = 13'd3;
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0000;
    $display("[TB] start");
    test_reset;
    monEn = 1'b1;
    test_cmd0;
    test_payload;
    test_reset_abort;
    test_back_to_back;
    test_max_len(13'd4096, 8'h28);
    test_max_len(13'h1FFF, 8'h29);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/osd_link_tx.md
OSD_LINK_TX -- requirements
Module: osd_link_tx

Interface
REQ-001 SHALL have parameter STB_HI, default 2: cycles io_strobe is held high per word (legal range 1..15).
REQ-002 SHALL have parameter STB_LO, default 3: cycles io_strobe is held low after each word (legal range 3..15).
REQ-003 SHALL have parameter IDLE_GAP, default 2: cycles io_osd is held low after a transaction before the next command is accepted (legal range 1..15).
REQ-004 SHALL use one clock and a synchronous, active-high reset; all ports are listed below.
REQ-005 clk_sys  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cmd_valid  in  1  command request.
REQ-008 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready are both high.
REQ-009 cmd_code  in  8  command byte, e.g. 0x20-0x3F write, 0x40-0x4F enable/disable.
REQ-010 cmd_len  in  13  number of payload words, 0..4096.
REQ-011 pay_addr  out  13  payload word index into a synchronous-read payload RAM.
REQ-012 pay_data  in  16  RAM read data, valid the cycle after pay_addr changes.
REQ-013 io_osd  out  1  transaction frame.
REQ-014 io_strobe  out  1  word strobe; the receiver samples on the rising edge.
REQ-015 io_din  out  16  word bus.
REQ-016 busy  out  1  equals ~cmd_ready.

Function
REQ-017 SHALL register every output (no combinational paths from inputs to outputs).
REQ-018 SHALL implement the states IDLE, SETUP, HI, LO, GAP.
REQ-019 SHALL assert cmd_ready only in IDLE.
REQ-020 SHALL latch cmd_code and cmd_len on acceptance and ignore both inputs until the next IDLE.
REQ-021 SHALL treat a cmd_len greater than 4096 as 4096.
REQ-022 SHALL, on the cycle after acceptance (T+1, SETUP), drive io_osd=1, io_din={8'h00,cmd_code}, io_strobe=0, for exactly 1 cycle.
REQ-023 SHALL, in HI, drive io_strobe=1 for STB_HI cycles, with io_din and io_osd stable.
REQ-024 SHALL, in LO, drive io_strobe=0 for STB_LO cycles, with io_osd=1.
REQ-025 SHALL, when word i (0-based) remains to be sent, update pay_addr to i on the first LO cycle.
REQ-026 SHALL, in that case, load io_din with pay_data at the end of the second LO cycle, so the word is visible from the third LO cycle onward and stable for at least 1 cycle before the strobe rises.
REQ-027 SHALL, after LO, return to HI while words remain, giving cmd_len+1 strobe pulses in total (command word plus payload).
REQ-028 SHALL, after the final LO, enter GAP: io_osd=0, io_strobe=0, io_din holding its last value, for IDLE_GAP cycles, then IDLE.
REQ-029 SHALL make the transaction length 1 + (cmd_len+1)*(STB_HI+STB_LO) cycles of io_osd high.
REQ-030 SHALL never emit two strobe rising edges without at least STB_LO low cycles between them.
REQ-031 SHALL, for cmd_len=0, emit only the command pulse; pay_addr is unchanged.
REQ-032 SHALL size pay_addr and the word counter at 13 bits with no wrap: the last index driven is cmd_len-1, maximum 4095.
REQ-033 SHALL, when cmd_valid is held high continuously, accept the next command on the first IDLE cycle; the IDLE_GAP low time SHALL always precede it.

Reset
REQ-034 SHALL, in the cycle after reset is sampled high, force IDLE with io_osd=0, io_strobe=0, io_din=0, pay_addr=0, cmd_ready=1, busy=0.
REQ-035 SHALL, on reset mid-transaction, abort immediately; io_osd dropping discards the partial transaction at the receiver, and no GAP is enforced.
REQ-036 SHALL ignore cmd_valid while reset is high.

Verification
REQ-037 Hold reset for 3 cycles, then release -> all outputs 0 and cmd_ready=1 on the first cycle after release; no strobe activity.
REQ-038 Defaults; accept cmd_code=0x40, cmd_len=0 at T -> io_osd=1 on T+1..T+6; io_din=0x0040; io_strobe=1 on T+2..T+3; io_osd=0 on T+7..T+8; cmd_ready=1 on T+9.
REQ-039 Accept cmd_code=0x41, cmd_len=5, RAM={0x0010,0x0020,0x0005,0x0003,0x0001} -> 6 rising strobes; io_din sampled at the rises = 0x0041,0x0010,0x0020,0x0005,0x0003,0x0001; pay_addr steps 0..4.
REQ-040 Accept cmd_code=0x28, cmd_len=4096, RAM[i]=i -> 4097 strobes; last io_din=0x0FFF; pay_addr ends at 4095; io_osd high for 1+4097*5 cycles.
REQ-041 Pulse reset for 1 cycle during the HI of word 2 in the REQ-039 scenario -> next cycle io_osd=0, io_strobe=0, cmd_ready=1; a new command accepted immediately runs the full sequence.
REQ-042 Hold cmd_valid high with two queued commands (lengths 1 and 0) -> the second is accepted exactly IDLE_GAP+1 cycles after io_osd falls; no overlap of frames.
